// File: rtl/reg_wb_pkg.sv
// Shared definitions for the register writeback block: default widths,
// writeback source select encodings and load funct3 encodings.
package reg_wb_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_NONE = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the byte/halfword addressed by the
// low address bits and sign- or zero-extends it to XLEN.
module load_align
    import reg_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_load_data,
    output logic [XLEN-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/halfword, then extend according to funct3.
    always_comb begin
        w_byte = i_load_data[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_load_data[31:16] : i_load_data[15:0];
        o_data = '0;
        case (i_funct3)
            F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
            F3_LW:   o_data = i_load_data;
            F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// Register writeback stage: a 2-entry result FIFO draining into the
// architectural register file, one retire per cycle unless held.
// Define WB_BYPASS_EN to forward the current-cycle write onto the read ports.
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_load_data,
    input  logic [XLEN-1:0] in_pc,
    input  logic            hold,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     retire_count
);

    // Entries are formatted on entry so the FIFO only holds the final value.
    logic [XLEN-1:0] r_regs    [NREG];
    logic [XLEN-1:0] r_fifo_data [2];
    logic [4:0]      r_fifo_rd   [2];
    logic            r_fifo_we   [2];
    logic            r_head;
    logic            r_tail;
    logic [1:0]      r_count;
    logic [31:0]     r_retire_count;

    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_entry_data;
    logic            w_entry_we;
    logic            w_accept;
    logic            w_retire;
    logic            w_head_we;

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_funct3    (in_funct3),
        .i_addr_lo   (in_addr_lo),
        .i_load_data (in_load_data),
        .o_data      (w_load_data)
    );

    // Select the result value for a new entry and whether it really writes.
    always_comb begin
        w_entry_data = '0;
        w_entry_we   = (in_rd != 5'd0) && (in_wb_sel != WB_SEL_NONE);
        case (wb_sel_e'(in_wb_sel))
            WB_SEL_ALU:  w_entry_data = in_alu_result;
            WB_SEL_LOAD: w_entry_data = w_load_data;
            WB_SEL_PC4:  w_entry_data = in_pc + XLEN'(4);
            default:     w_entry_data = '0;
        endcase
    end

    assign in_ready  = (r_count < 2'd2) && rst;
    assign w_accept  = in_valid && in_ready;
    assign w_retire  = (r_count != 2'd0) && !hold && rst;
    assign w_head_we = r_fifo_we[r_head];

    assign wb_valid     = w_retire && w_head_we;
    assign wb_rd        = wb_valid ? r_fifo_rd[r_head]   : 5'd0;
    assign wb_data      = wb_valid ? r_fifo_data[r_head] : '0;
    assign retire_count = r_retire_count;

    // FIFO bookkeeping, register file write and retire counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
            r_count        <= 2'd0;
            r_retire_count <= '0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_rd[i]   <= 5'd0;
                r_fifo_we[i]   <= 1'b0;
            end
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_fifo_data[r_tail] <= w_entry_data;
                r_fifo_rd[r_tail]   <= in_rd;
                r_fifo_we[r_tail]   <= w_entry_we;
                r_tail              <= ~r_tail;
            end
            if (w_retire) begin
                r_head         <= ~r_head;
                r_retire_count <= r_retire_count + 32'd1;
                if (w_head_we && (int'(r_fifo_rd[r_head]) < NREG)) begin
                    r_regs[r_fifo_rd[r_head]] <= r_fifo_data[r_head];
                end
            end
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Combinational read ports; register 0 always reads as zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if ((rs1_addr != 5'd0) && (int'(rs1_addr) < NREG)) rs1_data = r_regs[rs1_addr];
        if ((rs2_addr != 5'd0) && (int'(rs2_addr) < NREG)) rs2_data = r_regs[rs2_addr];
`ifdef WB_BYPASS_EN
        // wb_rd is non-zero whenever wb_valid is high, so no extra zero check.
        if (wb_valid && (rs1_addr == wb_rd)) rs1_data = wb_data;
        if (wb_valid && (rs2_addr == wb_rd)) rs2_data = wb_data;
`endif
    end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback (works with or without
// WB_BYPASS_EN defined).
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_load_data;
    logic [31:0] in_pc;
    logic        hold;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] retire_count;

    int n_err = 0;
    int n_chk = 0;

    reg_writeback dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .in_load_data  (in_load_data),
        .in_pc         (in_pc),
        .hold          (hold),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [31:0] pc);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_funct3     = f3;
        in_addr_lo    = alo;
        in_alu_result = alu;
        in_load_data  = ld;
        in_pc         = pc;
    endtask

    // Present one entry, let it be accepted, and land in its retire cycle.
    task automatic push(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [1:0] alo, input logic [31:0] alu,
                        input logic [31:0] ld, input logic [31:0] pc);
        drive(rd, sel, f3, alo, alu, ld, pc);
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
        rs2_addr = a;
        #1;
        d = rs2_data;
    endtask

    logic [31:0] rd_val;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_funct3 = '0;
        in_addr_lo = '0; in_alu_result = '0; in_load_data = '0; in_pc = '0;
        hold = 1'b0; rs1_addr = '0; rs2_addr = '0;
        step();
        step();

        // Reset state
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_retire_count", retire_count, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Basic ALU write to x5
        push(5'd5, 2'b00, 3'b000, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
        check_eq("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
        check_eq("alu_wb_rd", {27'd0, wb_rd}, 32'd5);
        check_eq("alu_wb_data", wb_data, 32'h1234_5678);
        step();
        read_reg(5'd5, rd_val);
        check_eq("alu_reg5", rd_val, 32'h1234_5678);
        check_eq("alu_retire_count", retire_count, 32'd1);
        check_eq("alu_wb_valid_idle", {31'd0, wb_valid}, 32'd0);

        // Load formatting
        push(5'd10, 2'b01, 3'b000, 2'd3, 32'h0, 32'h80FF_0000, 32'h0);
        check_eq("lb_wb_data", wb_data, 32'hFFFF_FF80);
        step();
        push(5'd11, 2'b01, 3'b100, 2'd3, 32'h0, 32'h80FF_0000, 32'h0);
        check_eq("lbu_wb_data", wb_data, 32'h0000_0080);
        step();
        push(5'd12, 2'b01, 3'b001, 2'd2, 32'h0, 32'h80FF_0000, 32'h0);
        check_eq("lh_wb_data", wb_data, 32'hFFFF_80FF);
        step();
        push(5'd13, 2'b01, 3'b011, 2'd0, 32'h0, 32'h80FF_0000, 32'h0);
        check_eq("bad_f3_wb_data", wb_data, 32'h0);
        step();
        read_reg(5'd10, rd_val);
        check_eq("lb_reg10", rd_val, 32'hFFFF_FF80);
        read_reg(5'd12, rd_val);
        check_eq("lh_reg12", rd_val, 32'hFFFF_80FF);
        push(5'd3, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0000_0100);
        check_eq("pc4_wb_data", wb_data, 32'h0000_0104);
        step();
        check_eq("load_retire_count", retire_count, 32'd6);

        // rd=0 and wb_sel=none still retire without writing
        push(5'd0, 2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        check_eq("rd0_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rd0_wb_data", wb_data, 32'h0);
        step();
        rs1_addr = 5'd0;
        #1;
        check_eq("rd0_read_x0", rs1_data, 32'h0);
        check_eq("rd0_retire_count", retire_count, 32'd7);
        push(5'd6, 2'b11, 3'b000, 2'd0, 32'h6666_6666, 32'h0, 32'h0);
        check_eq("none_wb_valid", {31'd0, wb_valid}, 32'd0);
        step();
        read_reg(5'd6, rd_val);
        check_eq("none_reg6", rd_val, 32'h0);
        check_eq("none_retire_count", retire_count, 32'd8);

        // Hold: two accepts fill the FIFO, nothing writes until release
        hold = 1'b1;
        drive(5'd1, 2'b00, 3'b000, 2'd0, 32'h11, 32'h0, 32'h0);
        step();
        drive(5'd2, 2'b00, 3'b000, 2'd0, 32'h22, 32'h0, 32'h0);
        step();
        drive(5'd4, 2'b00, 3'b000, 2'd0, 32'h44, 32'h0, 32'h0);
        #1;
        check_eq("hold_in_ready_full", {31'd0, in_ready}, 32'd0);
        check_eq("hold_wb_valid", {31'd0, wb_valid}, 32'd0);
        step();
        step();
        read_reg(5'd1, rd_val);
        check_eq("hold_reg1_unwritten", rd_val, 32'h0);
        check_eq("hold_retire_count", retire_count, 32'd8);
        hold = 1'b0;
        #1;
        check_eq("rel_wb_rd_a", {27'd0, wb_rd}, 32'd1);
        check_eq("rel_wb_data_a", wb_data, 32'h11);
        check_eq("rel_in_ready_a", {31'd0, in_ready}, 32'd0);
        step();
        check_eq("rel_wb_rd_b", {27'd0, wb_rd}, 32'd2);
        check_eq("rel_wb_data_b", wb_data, 32'h22);
        check_eq("rel_in_ready_b", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        check_eq("rel_wb_rd_c", {27'd0, wb_rd}, 32'd4);
        check_eq("rel_wb_data_c", wb_data, 32'h44);
        step();
        read_reg(5'd1, rd_val);
        check_eq("rel_reg1", rd_val, 32'h11);
        read_reg(5'd2, rd_val);
        check_eq("rel_reg2", rd_val, 32'h22);
        read_reg(5'd4, rd_val);
        check_eq("rel_reg4", rd_val, 32'h44);
        check_eq("rel_retire_count", retire_count, 32'd11);

        // Read during a write: bypass versus stored value
        push(5'd7, 2'b00, 3'b000, 2'd0, 32'h0000_1111, 32'h0, 32'h0);
        step();
        push(5'd7, 2'b00, 3'b000, 2'd0, 32'hA5A5_A5A5, 32'h0, 32'h0);
        rs1_addr = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        check_eq("byp_rs1_during_wb", rs1_data, 32'hA5A5_A5A5);
`else
        check_eq("nobyp_rs1_during_wb", rs1_data, 32'h0000_1111);
`endif
        step();
        check_eq("byp_rs1_after_wb", rs1_data, 32'hA5A5_A5A5);
        check_eq("byp_retire_count", retire_count, 32'd13);
        rs1_addr = 5'd0;

        // Reset with two entries pending
        hold = 1'b1;
        drive(5'd8, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        step();
        drive(5'd9, 2'b00, 3'b000, 2'd0, 32'h99, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        hold = 1'b0;
        #1;
        check_eq("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check_eq("mid_rst_retire_count", retire_count, 32'd0);
        read_reg(5'd9, rd_val);
        check_eq("mid_rst_reg9", rd_val, 32'h0);
        read_reg(5'd5, rd_val);
        check_eq("mid_rst_reg5_cleared", rd_val, 32'h0);
        rst = 1'b1;
        step();
        check_eq("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        push(5'd8, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        check_eq("post_rst_wb_valid_pc4", {31'd0, wb_valid}, 32'd1);
        check_eq("post_rst_wb_rd", {27'd0, wb_rd}, 32'd8);
        check_eq("post_rst_wb_data", wb_data, 32'h0);
        step();
        check_eq("post_rst_retire_count", retire_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
